// File: rtl/bsg_chip_pkg.sv
// ----------------------------------------------------------------------------
// bsg_chip_pkg
//
// Purpose: shared constants and types for the NoC link reset sequencer.
//   - state width and the state enumeration
//   - default hold length for each sequencing state
//   - the registered output bundle and a decode helper mapping a state onto
//     the reset levels it drives
//
// Ports: none (package).
// ----------------------------------------------------------------------------
package bsg_chip_pkg;

    localparam int noc_link_reset_state_width_gp = 3;
    localparam int noc_link_reset_hold_cycles_gp = 16;

    typedef enum logic [noc_link_reset_state_width_gp-1:0] {
        e_lrs_idle    = 3'd0,
        e_lrs_tok_hi  = 3'd1,
        e_lrs_tok_lo  = 3'd2,
        e_lrs_up      = 3'd3,
        e_lrs_down    = 3'd4,
        e_lrs_dstream = 3'd5,
        e_lrs_done    = 3'd6
    } noc_link_reset_state_e;

    typedef struct packed {
        logic token_reset;
        logic uplink_reset;
        logic downlink_reset;
        logic downstream_reset;
        logic noc_reset;
        logic busy;
        logic done;
    } noc_link_reset_outs_s;

    // Levels seen in IDLE and while reset_i is held.
    localparam noc_link_reset_outs_s noc_link_reset_outs_idle_gp = '{
        token_reset:      1'b0,
        uplink_reset:     1'b1,
        downlink_reset:   1'b1,
        downstream_reset: 1'b1,
        noc_reset:        1'b1,
        busy:             1'b0,
        done:             1'b0
    };

    // Map a state onto its output levels; the unused encoding maps to IDLE.
    function automatic noc_link_reset_outs_s noc_link_reset_decode(
        input logic [noc_link_reset_state_width_gp-1:0] state
    );
        noc_link_reset_outs_s o;
        o = noc_link_reset_outs_idle_gp;
        case (state)
            e_lrs_tok_hi: begin
                o.token_reset = 1'b1;
                o.busy        = 1'b1;
            end
            e_lrs_tok_lo: begin
                o.busy = 1'b1;
            end
            e_lrs_up: begin
                o.uplink_reset = 1'b0;
                o.busy         = 1'b1;
            end
            e_lrs_down: begin
                o.uplink_reset   = 1'b0;
                o.downlink_reset = 1'b0;
                o.busy           = 1'b1;
            end
            e_lrs_dstream: begin
                o.uplink_reset     = 1'b0;
                o.downlink_reset   = 1'b0;
                o.downstream_reset = 1'b0;
                o.busy             = 1'b1;
            end
            e_lrs_done: begin
                o.uplink_reset     = 1'b0;
                o.downlink_reset   = 1'b0;
                o.downstream_reset = 1'b0;
                o.noc_reset        = 1'b0;
                o.done             = 1'b1;
            end
            default: begin
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/bsg_chip_noc_link_reset_sequencer_if.sv
// ----------------------------------------------------------------------------
// bsg_chip_noc_link_reset_sequencer_if
//
// Purpose: bundles the control and status signals of the link reset
// sequencer so a bring-up controller and monitors can share one handle.
//
// Signal protocol: there is no valid/ready pair. start and restart are
// level-sampled on every rising clock edge; start only matters while the
// sequencer is idle, restart wins over start whenever both are high. All
// status outputs are registered and change only on a clock edge or on the
// asynchronous reset.
//
// Signals:
//   start, restart                 - controller -> sequencer
//   token_reset, uplink_reset,
//   downlink_reset, downstream_reset,
//   noc_reset                      - sequencer -> link resets
//   busy, done, state              - sequencer -> status/debug
// Modports: master (controller side), slave (sequencer side).
// ----------------------------------------------------------------------------
interface bsg_chip_noc_link_reset_sequencer_if;

    logic                                                  start;
    logic                                                  restart;
    logic                                                  token_reset;
    logic                                                  uplink_reset;
    logic                                                  downlink_reset;
    logic                                                  downstream_reset;
    logic                                                  noc_reset;
    logic                                                  busy;
    logic                                                  done;
    logic [bsg_chip_pkg::noc_link_reset_state_width_gp-1:0] state;

    modport master (
        output start, restart,
        input  token_reset, uplink_reset, downlink_reset, downstream_reset,
        input  noc_reset, busy, done, state
    );

    modport slave (
        input  start, restart,
        output token_reset, uplink_reset, downlink_reset, downstream_reset,
        output noc_reset, busy, done, state
    );

endinterface

// File: rtl/bsg_counter_set_down.sv
// ----------------------------------------------------------------------------
// bsg_counter_set_down
//
// Purpose: loadable down-counter. A load takes priority over a decrement;
// the counter does not wrap on its own because the owner only requests a
// decrement while the count is non-zero.
//
// Ports:
//   clk_i      - clock
//   reset_i    - asynchronous active-high reset, clears the count
//   set_i      - load val_i
//   val_i      - load value
//   down_i     - decrement by one
//   count_r_o  - registered count
// ----------------------------------------------------------------------------
module bsg_counter_set_down #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               set_i,
    input  logic [width_p-1:0] val_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_r_o
);

    localparam logic [width_p-1:0] one_lp = width_p'(1);

    logic [width_p-1:0] r_count;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (set_i) begin
            r_count <= val_i;
        end else if (down_i) begin
            r_count <= r_count - one_lp;
        end
    end

    assign count_r_o = r_count;

endmodule

// File: rtl/bsg_chip_noc_link_reset_sequencer.sv
// ----------------------------------------------------------------------------
// bsg_chip_noc_link_reset_sequencer
//
// Purpose: brings a NoC link out of reset in a fixed order. After a start
// the async token reset is pulsed, then uplink, downlink, downstream and
// finally the tunnel/arbiter/adapter (noc) resets are released, each step
// held for hold_cycles_p clocks. restart_i returns to IDLE from anywhere.
//
// Build option: BSG_NOC_LINK_RESET_SEQ_AUTO_START_EN
//   defined   - one implicit start is issued on the first full clock cycle
//               after reset_i deasserts; later runs still need start_i.
//   undefined - the sequence only begins on start_i.
//
// Ports:
//   clk_i               - NoC core clock
//   reset_i             - asynchronous active-high reset
//   start_i             - begin bring-up (sampled only in IDLE)
//   restart_i           - abort / finish, back to IDLE (beats start_i)
//   token_reset_o       - SDR/DDR async token reset
//   uplink_reset_o      - core uplink reset
//   downlink_reset_o    - async downlink reset
//   downstream_reset_o  - core downstream reset
//   noc_reset_o         - tunnel, arbiter and adapter reset
//   busy_o              - sequencing in progress (not IDLE, not DONE)
//   done_o              - sequence complete
//   state_o             - current state encoding (debug)
// ----------------------------------------------------------------------------
module bsg_chip_noc_link_reset_sequencer
    import bsg_chip_pkg::*;
#(
    parameter int hold_cycles_p = noc_link_reset_hold_cycles_gp
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic                                     start_i,
    input  logic                                     restart_i,
    output logic                                     token_reset_o,
    output logic                                     uplink_reset_o,
    output logic                                     downlink_reset_o,
    output logic                                     downstream_reset_o,
    output logic                                     noc_reset_o,
    output logic                                     busy_o,
    output logic                                     done_o,
    output logic [noc_link_reset_state_width_gp-1:0] state_o
);

    localparam int sw_lp = noc_link_reset_state_width_gp;

    localparam logic [sw_lp-1:0] S_IDLE    = e_lrs_idle;
    localparam logic [sw_lp-1:0] S_TOK_HI  = e_lrs_tok_hi;
    localparam logic [sw_lp-1:0] S_TOK_LO  = e_lrs_tok_lo;
    localparam logic [sw_lp-1:0] S_UP      = e_lrs_up;
    localparam logic [sw_lp-1:0] S_DOWN    = e_lrs_down;
    localparam logic [sw_lp-1:0] S_DSTREAM = e_lrs_dstream;
    localparam logic [sw_lp-1:0] S_DONE    = e_lrs_done;

    localparam int                  cnt_w_lp     = $clog2(hold_cycles_p + 1);
    // Loading H-1 and leaving when the count reads zero gives H cycles.
    localparam logic [cnt_w_lp-1:0] hold_load_lp = cnt_w_lp'(hold_cycles_p - 1);

    logic [sw_lp-1:0]     r_state;
    logic [sw_lp-1:0]     w_next_state;
    logic [cnt_w_lp-1:0]  w_count;
    logic [cnt_w_lp-1:0]  w_cnt_val;
    logic                 w_cnt_set;
    logic                 w_cnt_down;
    logic                 w_count_zero;
    logic                 w_hold_state;
    logic                 w_next_hold;
    logic                 w_start;
    noc_link_reset_outs_s r_outs;

`ifdef BSG_NOC_LINK_RESET_SEQ_AUTO_START_EN
    // r_auto_arm is set by reset; the first edge after release moves it into
    // r_auto_start, which acts as start_i for exactly one cycle.
    logic r_auto_arm;
    logic r_auto_start;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_auto_arm   <= 1'b1;
            r_auto_start <= 1'b0;
        end else begin
            r_auto_arm   <= 1'b0;
            r_auto_start <= r_auto_arm;
        end
    end

    assign w_start = start_i | r_auto_start;
`else
    assign w_start = start_i;
`endif

    assign w_count_zero = (w_count == '0);
    assign w_hold_state = (r_state >= S_TOK_HI) && (r_state <= S_DSTREAM);
    assign w_next_hold  = (w_next_state >= S_TOK_HI) && (w_next_state <= S_DSTREAM);

    always_comb begin
        w_next_state = r_state;
        if (restart_i) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_start)      w_next_state = S_TOK_HI;
                S_TOK_HI:  if (w_count_zero) w_next_state = S_TOK_LO;
                S_TOK_LO:  if (w_count_zero) w_next_state = S_UP;
                S_UP:      if (w_count_zero) w_next_state = S_DOWN;
                S_DOWN:    if (w_count_zero) w_next_state = S_DSTREAM;
                S_DSTREAM: if (w_count_zero) w_next_state = S_DONE;
                S_DONE:    w_next_state = S_DONE;
                default:   w_next_state = S_IDLE;
            endcase
        end
    end

    // Any state change reloads the counter: hold length on entry to a timed
    // state, zero on entry to IDLE/DONE so the count is clean there.
    assign w_cnt_set  = (w_next_state != r_state);
    assign w_cnt_val  = w_next_hold ? hold_load_lp : '0;
    assign w_cnt_down = w_hold_state && !w_count_zero && !w_cnt_set;

    bsg_counter_set_down #(
        .width_p (cnt_w_lp)
    ) u_hold_cnt (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .set_i     (w_cnt_set),
        .val_i     (w_cnt_val),
        .down_i    (w_cnt_down),
        .count_r_o (w_count)
    );

    // Outputs are registered from the next-state decode so they move on the
    // same edge as the state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_outs  <= noc_link_reset_outs_idle_gp;
        end else begin
            r_state <= w_next_state;
            r_outs  <= noc_link_reset_decode(w_next_state);
        end
    end

    assign token_reset_o      = r_outs.token_reset;
    assign uplink_reset_o     = r_outs.uplink_reset;
    assign downlink_reset_o   = r_outs.downlink_reset;
    assign downstream_reset_o = r_outs.downstream_reset;
    assign noc_reset_o        = r_outs.noc_reset;
    assign busy_o             = r_outs.busy;
    assign done_o             = r_outs.done;
    assign state_o            = r_state;

endmodule

// File: tb/tb_bsg_chip_noc_link_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_bsg_chip_noc_link_reset_sequencer
//
// Two sequencer instances share clock and reset: dut_a with hold 4 and
// dut_b with hold 1. Output bundles compared as
// {state[2:0], token, uplink, downlink, downstream, noc, busy, done}.
// Cycle n is the interval just after the n-th rising edge counted from the
// reference point of each scenario.
// ----------------------------------------------------------------------------
module tb_bsg_chip_noc_link_reset_sequencer;

    localparam logic [9:0] RST_V = {3'd0, 1'b0, 4'b1111, 1'b0, 1'b0};

    logic clk;
    logic rst;
    int   c;
    int   checks;
    int   errors;

    bsg_chip_noc_link_reset_sequencer_if a_if ();
    bsg_chip_noc_link_reset_sequencer_if b_if ();

    bsg_chip_noc_link_reset_sequencer #(.hold_cycles_p(4)) dut_a (
        .clk_i              (clk),
        .reset_i            (rst),
        .start_i            (a_if.start),
        .restart_i          (a_if.restart),
        .token_reset_o      (a_if.token_reset),
        .uplink_reset_o     (a_if.uplink_reset),
        .downlink_reset_o   (a_if.downlink_reset),
        .downstream_reset_o (a_if.downstream_reset),
        .noc_reset_o        (a_if.noc_reset),
        .busy_o             (a_if.busy),
        .done_o             (a_if.done),
        .state_o            (a_if.state)
    );

    bsg_chip_noc_link_reset_sequencer #(.hold_cycles_p(1)) dut_b (
        .clk_i              (clk),
        .reset_i            (rst),
        .start_i            (b_if.start),
        .restart_i          (b_if.restart),
        .token_reset_o      (b_if.token_reset),
        .uplink_reset_o     (b_if.uplink_reset),
        .downlink_reset_o   (b_if.downlink_reset),
        .downstream_reset_o (b_if.downstream_reset),
        .noc_reset_o        (b_if.noc_reset),
        .busy_o             (b_if.busy),
        .done_o             (b_if.done),
        .state_o            (b_if.state)
    );

    logic [9:0] w_obs_a;
    logic [9:0] w_obs_b;

    assign w_obs_a = {a_if.state, a_if.token_reset, a_if.uplink_reset, a_if.downlink_reset,
                      a_if.downstream_reset, a_if.noc_reset, a_if.busy, a_if.done};
    assign w_obs_b = {b_if.state, b_if.token_reset, b_if.uplink_reset, b_if.downlink_reset,
                      b_if.downstream_reset, b_if.noc_reset, b_if.busy, b_if.done};

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: advance one cycle and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %b required %b", tag, c, obs, exp);
        end
    endtask

    // Expected bundle for a run started (start high) in cycle s with hold h,
    // straight from the timeline: token high s+1..s+h, uplink falls s+2h+1,
    // downlink s+3h+1, downstream s+4h+1, noc/done s+5h+1.
    function automatic logic [9:0] exp_seq(input int cyc, input int s, input int h);
        logic [2:0] st;
        logic       tok, up, dn, ds, noc, busy, done;
        int         k;
        if (cyc <= s) begin
            st = 3'd0;
        end else begin
            k  = (cyc - s - 1) / h;
            st = (k >= 5) ? 3'd6 : 3'(k + 1);
        end
        tok  = (cyc >= s + 1) && (cyc <= s + h);
        up   = (cyc < s + 2*h + 1);
        dn   = (cyc < s + 3*h + 1);
        ds   = (cyc < s + 4*h + 1);
        noc  = (cyc < s + 5*h + 1);
        done = (cyc >= s + 5*h + 1);
        busy = (st != 3'd0) && (st != 3'd6);
        return {st, tok, up, dn, ds, noc, busy, done};
    endfunction

    initial begin
        checks       = 0;
        errors       = 0;
        c            = 0;
        rst          = 1'b1;
        a_if.start   = 1'b0;
        a_if.restart = 1'b0;
        b_if.start   = 1'b0;
        b_if.restart = 1'b0;

        // Reset values, before and after edges with reset held.
        #3;
        check("reset_a", w_obs_a, RST_V);
        check("reset_b", w_obs_b, RST_V);
        a_if.start = 1'b1;
        tick();
        tick();
        check("reset_held_a", w_obs_a, RST_V);
        a_if.start = 1'b0;
        rst = 1'b0;

        // Nominal bring-up, H=4, start in cycle 10; start pulses in cycle 16
        // (mid-sequence) and 33 (DONE) must be ignored.
        c = 0;
        while (c < 10) begin
            tick();
            check("idle_a", w_obs_a, RST_V);
        end
        a_if.start = 1'b1;
        while (c < 34) begin
            tick();
            a_if.start = (c == 16) || (c == 33);
            check("nominal", w_obs_a, exp_seq(c, 10, 4));
        end
        a_if.start = 1'b0;

        a_if.restart = 1'b1;
        tick();
        a_if.restart = 1'b0;
        check("restart_from_done", w_obs_a, RST_V);

        // Mid-sequence restart in cycle 20, new start in cycle 25.
        c = 0;
        while (c < 10) tick();
        a_if.start = 1'b1;
        while (c < 20) begin
            tick();
            a_if.start = 1'b0;
            check("midseq", w_obs_a, exp_seq(c, 10, 4));
        end
        a_if.restart = 1'b1;
        tick();
        a_if.restart = 1'b0;
        check("midseq_restart", w_obs_a, RST_V);
        while (c < 25) begin
            tick();
            check("post_restart_idle", w_obs_a, RST_V);
        end
        a_if.start = 1'b1;
        while (c < 47) begin
            tick();
            a_if.start = 1'b0;
            check("second_start", w_obs_a, exp_seq(c, 25, 4));
        end

        // Back to IDLE, then start and restart together.
        a_if.restart = 1'b1;
        tick();
        check("restart_from_done2", w_obs_a, RST_V);
        a_if.start = 1'b1;
        tick();
        check("start_and_restart_1", w_obs_a, RST_V);
        tick();
        check("start_and_restart_2", w_obs_a, RST_V);
        a_if.start   = 1'b0;
        a_if.restart = 1'b0;
        tick();
        check("idle_after_both", w_obs_a, RST_V);

        // Asynchronous reset while in DOWN (cycles 23..26 for start at 10).
        c = 0;
        while (c < 10) tick();
        a_if.start = 1'b1;
        while (c < 24) begin
            tick();
            a_if.start = 1'b0;
            check("pre_async_reset", w_obs_a, exp_seq(c, 10, 4));
        end
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_a", w_obs_a, RST_V);
        check("async_reset_b", w_obs_b, RST_V);
        tick();
        check("async_reset_held", w_obs_a, RST_V);
        rst = 1'b0;
`ifndef BSG_NOC_LINK_RESET_SEQ_AUTO_START_EN
        repeat (3) begin
            tick();
            check("no_resume_after_reset", w_obs_a, RST_V);
        end
`endif

        // Minimum hold, H=1, start in cycle 5.
        c = 0;
        while (c < 5) begin
            tick();
            check("idle_b", w_obs_b, RST_V);
        end
        b_if.start = 1'b1;
        while (c < 12) begin
            tick();
            b_if.start = 1'b0;
            check("min_hold", w_obs_b, exp_seq(c, 5, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_chip_noc_link_reset_sequencer.md
BSG_CHIP_NOC_LINK_RESET_SEQUENCER -- requirements
Module: bsg_chip_noc_link_reset_sequencer

Interface
REQ-001 SHALL have parameter hold_cycles_p, default 16: number of clk_i cycles each sequencing state is held; legal range is 1..65535.
REQ-002 SHALL have port clk_i, input, 1 bit: the NoC core clock.
REQ-003 SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start_i, input, 1 bit: begins link bring-up; sampled only in IDLE.
REQ-005 SHALL have port restart_i, input, 1 bit: aborts or ends the sequence and returns to IDLE from any state.
REQ-006 SHALL have port token_reset_o, output, 1 bit: drives the SDR/DDR async token reset.
REQ-007 SHALL have port uplink_reset_o, output, 1 bit: drives the core uplink reset.
REQ-008 SHALL have port downlink_reset_o, output, 1 bit: drives the async downlink reset.
REQ-009 SHALL have port downstream_reset_o, output, 1 bit: drives the core downstream reset.
REQ-010 SHALL have port noc_reset_o, output, 1 bit: drives the reset of the tunnel, arbiter and adapters.
REQ-011 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE and DONE.
REQ-012 SHALL have port done_o, output, 1 bit: high only in DONE.
REQ-013 SHALL have port state_o, output, 3 bits: encoded current state.

Function
REQ-014 SHALL implement the states IDLE=0, TOK_HI=1, TOK_LO=2, UP=3, DOWN=4, DSTREAM=5 and DONE=6; encoding 7 SHALL be unreachable and SHALL recover to IDLE.
REQ-015 SHALL register all outputs; each output SHALL be decoded from the next state so that it changes in the same cycle the state register changes.
REQ-016 SHALL drive the outputs per state as follows:
- IDLE: uplink, downlink, downstream and noc resets = 1; token_reset = 0.
- TOK_HI: as IDLE, except token_reset = 1.
- TOK_LO: as IDLE.
- UP: uplink_reset = 0.
- DOWN: uplink_reset and downlink_reset = 0.
- DSTREAM: uplink, downlink and downstream resets = 0.
- DONE: all resets = 0, token_reset = 0, done_o = 1.
REQ-017 SHALL leave IDLE for TOK_HI one cycle after start_i=1 is sampled in IDLE.
REQ-018 SHALL hold each of TOK_HI, TOK_LO, UP, DOWN and DSTREAM for exactly hold_cycles_p cycles, using a down-counter of width $clog2(hold_cycles_p+1) loaded on state entry, then advance in the order TOK_HI, TOK_LO, UP, DOWN, DSTREAM, DONE.
REQ-019 SHALL, for start sampled at cycle t with H=hold_cycles_p, produce:
- token_reset_o=1 for cycles t+1 through t+H;
- uplink_reset_o falling at t+2H+1;
- downlink_reset_o falling at t+3H+1;
- downstream_reset_o falling at t+4H+1;
- noc_reset_o falling and done_o rising at t+5H+1.
REQ-020 SHALL remain in DONE until restart_i=1 is sampled.
REQ-021 SHALL ignore start_i outside IDLE.
REQ-022 SHALL, on restart_i=1 in any state, enter IDLE the next cycle, reasserting all resets and clearing the counter.
REQ-023 SHALL give restart_i priority over start_i when both are high; the block SHALL stay in IDLE.
REQ-024 SHALL not advance the counter while in IDLE or DONE.

Reset
REQ-025 SHALL, while reset_i=1 and asynchronously, force the following:
- state = IDLE and counter = 0;
- uplink, downlink, downstream and noc resets = 1;
- token_reset_o = 0, busy_o = 0, done_o = 0.
REQ-026 SHALL, if reset_i is asserted mid-sequence, abandon the sequence; it SHALL restart only on a new start_i, or automatically per REQ-028.

Configuration
REQ-027 SHALL, when BSG_NOC_LINK_RESET_SEQ_AUTO_START_EN is undefined, begin the sequence only on start_i.
REQ-028 SHALL, when BSG_NOC_LINK_RESET_SEQ_AUTO_START_EN is defined, treat the first clk_i cycle after reset_i deasserts as an implicit start_i; restart_i SHALL still return the block to IDLE, and start_i SHALL be required after a restart.

Structure
REQ-029 SHALL place the state enum typedef and the 3-bit state width constant in bsg_chip_pkg, and default hold_cycles_p from a package constant, noc_link_reset_hold_cycles_gp.
REQ-030 SHALL instantiate one sub-module, bsg_counter_set_down, for the hold counter; all other logic SHALL be local to this block.

Verification
REQ-031 SHALL cover nominal bring-up: H=4, start_i pulsed at cycle 10 -> token_reset_o high cycles 11-14; uplink_reset_o falls at 19; downlink_reset_o at 23; downstream_reset_o at 27; noc_reset_o falls and done_o rises at 31.
REQ-032 SHALL cover mid-sequence restart: H=4, start at 10, restart_i at 20 -> state_o=0 and all four core resets=1 at 21; a new start at 25 -> done_o at 46.
REQ-033 SHALL cover simultaneous inputs: start_i and restart_i both high in IDLE -> state_o remains 0 and busy_o remains 0.
REQ-034 SHALL cover async reset: reset_i asserted between clock edges while in DOWN -> outputs return to reset values before the next edge; done_o=0.
REQ-035 SHALL cover the minimum hold: H=1, start at 5 -> token high at 6 only; done_o at 11.
REQ-036 SHALL cover auto-start: macro defined, H=2, reset_i released before cycle 3 -> done_o at 14 with no start_i.
